attn_job_sched: RTL and testbench

//  Job controller for the 4x4x128 MHA4 attention top.
//  - Serialises a valid/ready load stream into the Q/K/V init-SRAM write ports.
//  - Issues the one-cycle start pulse to the attention top.
//  - Counts out_valid beats and waits for done, with a timeout watchdog.
//  - Reports per-job status to the host side.

---
 rtl/attn_ctrl_pkg.sv | 33 +++
 rtl/attn_init_port_drv.sv | 51 +++++
 rtl/attn_job_sched.sv | 202 ++++++++++++++++++++
 tb/tb_attn_job_sched.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/attn_ctrl_pkg.sv
// rtl/attn_ctrl_pkg.sv - shared types and constants for the attention job controller
//
// Holds the controller state encoding, the load-select codes, the expected
// output beat count of the MHA4 attention top, and the init-port bundle type.
package attn_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } state_e;

  // ld_sel codes; SEL_BAD is consumed but never written anywhere
  localparam logic [1:0] SEL_Q   = 2'd0;
  localparam logic [1:0] SEL_K   = 2'd1;
  localparam logic [1:0] SEL_V   = 2'd2;
  localparam logic [1:0] SEL_BAD = 2'd3;

  // 4 rows x 32 groups of output beats per job
  localparam int ATTN_EXP_OUT = 128;

  localparam int ATTN_ADDR_W = 7;
  localparam int ATTN_DATA_W = 128;

  typedef struct packed {
    logic                   en;
    logic                   we_n;
    logic [ATTN_ADDR_W-1:0] addr;
    logic [ATTN_DATA_W-1:0] din;
  } init_port_t;

endpackage

// File: rtl/attn_init_port_drv.sv
// rtl/attn_init_port_drv.sv - registered init-SRAM write port driver with 1-cycle write pulse
//
// Purpose: turns an accepted load beat addressed to this port (ld_sel ==
// PORT_SEL) into a single-cycle write (en=1, we_n=0) on the following cycle.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   ld_fire                  a load beat was accepted this cycle
//   ld_sel, ld_addr, ld_data the accepted beat
//   init_en, init_we_n       registered enable / active-low write strobe
//   init_addr, init_din      registered address / data, held between writes
module attn_init_port_drv
  import attn_ctrl_pkg::*;
#(
  parameter int         ADDR_W   = 7,
  parameter int         DATA_W   = 128,
  parameter logic [1:0] PORT_SEL = SEL_Q
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_fire,
  input  logic [1:0]        ld_sel,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              init_en,
  output logic              init_we_n,
  output logic [ADDR_W-1:0] init_addr,
  output logic [DATA_W-1:0] init_din
);

  logic wr;
  assign wr = ld_fire && (ld_sel == PORT_SEL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_en   <= 1'b0;
      init_we_n <= 1'b1;
      init_addr <= '0;
      init_din  <= '0;
    end else begin
      // strobe is re-evaluated every cycle, so a write lasts exactly one cycle
      // and back-to-back beats to the same port produce back-to-back writes
      init_en   <= wr;
      init_we_n <= !wr;
      if (wr) begin
        init_addr <= ld_addr;
        init_din  <= ld_data;
      end
    end
  end

endmodule

// File: rtl/attn_job_sched.sv
// rtl/attn_job_sched.sv - job controller for the 4x4x128 MHA4 attention top
//
// Purpose: serialises the Q/K/V load stream into the init-SRAM write ports,
// issues the start pulse, counts output beats until done (with a watchdog),
// and reports per-job status.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   ld_valid/ld_ready/ld_sel/ld_addr/ld_data   load beat stream
//   go_valid/go_ready              job request handshake
//   {q,k,v}_init_*                 init-SRAM write ports
//   attn_start                     1-cycle start pulse to the attention top
//   attn_out_valid, attn_done      output beat and done from the attention top
//   busy, job_done, job_ok         job progress / completion status
//   err_timeout, err_count         last-job error flags
//   err_bad_sel                    sticky illegal-select flag, cleared at go accept
//   out_cnt                        saturating output beat count
module attn_job_sched
  import attn_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 128,
  parameter int EXP_OUT = ATTN_EXP_OUT,
  parameter int TIMEOUT = 600000,
  parameter int CNT_W   = $clog2(EXP_OUT + 1),
  parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [1:0]        ld_sel,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              go_valid,
  output logic              go_ready,
  output logic              q_init_en,
  output logic              q_init_we_n,
  output logic [ADDR_W-1:0] q_init_addr,
  output logic [DATA_W-1:0] q_init_din,
  output logic              k_init_en,
  output logic              k_init_we_n,
  output logic [ADDR_W-1:0] k_init_addr,
  output logic [DATA_W-1:0] k_init_din,
  output logic              v_init_en,
  output logic              v_init_we_n,
  output logic [ADDR_W-1:0] v_init_addr,
  output logic [DATA_W-1:0] v_init_din,
  output logic              attn_start,
  input  logic              attn_out_valid,
  input  logic              attn_done,
  output logic              busy,
  output logic              job_done,
  output logic              job_ok,
  output logic              err_timeout,
  output logic              err_count,
  output logic              err_bad_sel,
  output logic [CNT_W-1:0]  out_cnt
);

  localparam logic [CNT_W-1:0] EXP_CNT = CNT_W'(EXP_OUT);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  state_e          state;
  logic            wr_pend;
  logic            ovf;
  logic [TO_W-1:0] wd;

  logic             ld_fire;
  logic             go_fire;
  logic             cnt_full;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_nxt;
  logic             cnt_bad;
  logic             timeout;

  // A pending load (this cycle's beat or last cycle's write) blocks go, so a
  // job never starts before its operands have landed in the SRAMs.
  assign ld_ready = (state == IDLE);
  assign go_ready = (state == IDLE) && !ld_valid && !wr_pend;
  assign ld_fire  = ld_valid && ld_ready;
  assign go_fire  = go_valid && go_ready;

  // Beat arriving in the done cycle is folded in before the final check.
  assign cnt_full = (out_cnt == EXP_CNT);
  assign cnt_nxt  = (attn_out_valid && !cnt_full) ? out_cnt + 1'b1 : out_cnt;
  assign ovf_nxt  = ovf || (attn_out_valid && cnt_full);
  assign cnt_bad  = ovf_nxt || (cnt_nxt != EXP_CNT);
  assign timeout  = (wd == TO_LAST);

  attn_init_port_drv #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PORT_SEL(SEL_Q)) u_q_drv (
    .clk       (clk),
    .rst       (rst),
    .ld_fire   (ld_fire),
    .ld_sel    (ld_sel),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .init_en   (q_init_en),
    .init_we_n (q_init_we_n),
    .init_addr (q_init_addr),
    .init_din  (q_init_din)
  );

  attn_init_port_drv #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PORT_SEL(SEL_K)) u_k_drv (
    .clk       (clk),
    .rst       (rst),
    .ld_fire   (ld_fire),
    .ld_sel    (ld_sel),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .init_en   (k_init_en),
    .init_we_n (k_init_we_n),
    .init_addr (k_init_addr),
    .init_din  (k_init_din)
  );

  attn_init_port_drv #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PORT_SEL(SEL_V)) u_v_drv (
    .clk       (clk),
    .rst       (rst),
    .ld_fire   (ld_fire),
    .ld_sel    (ld_sel),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .init_en   (v_init_en),
    .init_we_n (v_init_we_n),
    .init_addr (v_init_addr),
    .init_din  (v_init_din)
  );

  // wr_pend covers the cycle in which the accepted beat is being written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_pend     <= 1'b0;
      err_bad_sel <= 1'b0;
    end else begin
      wr_pend <= ld_fire;
      if (go_fire) begin
        err_bad_sel <= 1'b0;
      end else if (ld_fire && (ld_sel == SEL_BAD)) begin
        err_bad_sel <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      attn_start  <= 1'b0;
      job_done    <= 1'b0;
      job_ok      <= 1'b0;
      err_timeout <= 1'b0;
      err_count   <= 1'b0;
      out_cnt     <= '0;
      wd          <= '0;
      ovf         <= 1'b0;
    end else begin
      attn_start <= 1'b0;
      job_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (go_fire) begin
            // clear job status so it reads 0 throughout START
            state       <= START;
            busy        <= 1'b1;
            attn_start  <= 1'b1;
            out_cnt     <= '0;
            wd          <= '0;
            ovf         <= 1'b0;
            job_ok      <= 1'b0;
            err_timeout <= 1'b0;
            err_count   <= 1'b0;
          end
        end
        START: begin
          state <= RUN;
        end
        RUN: begin
          out_cnt <= cnt_nxt;
          ovf     <= ovf_nxt;
          wd      <= wd + 1'b1;
          // done takes priority over a coincident timeout
          if (attn_done || timeout) begin
            state       <= REPORT;
            job_done    <= 1'b1;
            err_timeout <= !attn_done;
            err_count   <= cnt_bad;
            job_ok      <= attn_done && !cnt_bad;
          end
        end
        REPORT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_attn_job_sched.sv
// tb/tb_attn_job_sched.sv - self-checking bench for attn_job_sched
module tb_attn_job_sched;
  import attn_ctrl_pkg::*;

  localparam int EXP      = 128;
  localparam int TO_MAIN  = 400;
  localparam int TO_SHORT = 50;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic         ld_valid, ld_ready, go_valid, go_ready;
  logic [1:0]   ld_sel;
  logic [6:0]   ld_addr;
  logic [127:0] ld_data;
  logic         q_en, q_we_n, k_en, k_we_n, v_en, v_we_n;
  logic [6:0]   q_addr, k_addr, v_addr;
  logic [127:0] q_din, k_din, v_din;
  logic         attn_start, attn_out_valid, attn_done;
  logic         busy, job_done, job_ok, err_timeout, err_count, err_bad_sel;
  logic [7:0]   out_cnt;

  // short-watchdog instance, used only for the timeout scenarios
  logic         t_ld_valid, t_ld_ready, t_go_valid, t_go_ready;
  logic [1:0]   t_ld_sel;
  logic [6:0]   t_ld_addr;
  logic [127:0] t_ld_data;
  logic         t_q_en, t_q_we_n, t_k_en, t_k_we_n, t_v_en, t_v_we_n;
  logic [6:0]   t_q_addr, t_k_addr, t_v_addr;
  logic [127:0] t_q_din, t_k_din, t_v_din;
  logic         t_start, t_out_valid, t_done;
  logic         t_busy, t_job_done, t_job_ok, t_err_timeout, t_err_count, t_err_bad_sel;
  logic [7:0]   t_out_cnt;

  attn_job_sched #(.TIMEOUT(TO_MAIN)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
    .go_valid(go_valid), .go_ready(go_ready),
    .q_init_en(q_en), .q_init_we_n(q_we_n), .q_init_addr(q_addr), .q_init_din(q_din),
    .k_init_en(k_en), .k_init_we_n(k_we_n), .k_init_addr(k_addr), .k_init_din(k_din),
    .v_init_en(v_en), .v_init_we_n(v_we_n), .v_init_addr(v_addr), .v_init_din(v_din),
    .attn_start(attn_start), .attn_out_valid(attn_out_valid), .attn_done(attn_done),
    .busy(busy), .job_done(job_done), .job_ok(job_ok), .err_timeout(err_timeout),
    .err_count(err_count), .err_bad_sel(err_bad_sel), .out_cnt(out_cnt)
  );

  attn_job_sched #(.TIMEOUT(TO_SHORT)) dut_to (
    .clk(clk), .rst(rst),
    .ld_valid(t_ld_valid), .ld_ready(t_ld_ready), .ld_sel(t_ld_sel), .ld_addr(t_ld_addr), .ld_data(t_ld_data),
    .go_valid(t_go_valid), .go_ready(t_go_ready),
    .q_init_en(t_q_en), .q_init_we_n(t_q_we_n), .q_init_addr(t_q_addr), .q_init_din(t_q_din),
    .k_init_en(t_k_en), .k_init_we_n(t_k_we_n), .k_init_addr(t_k_addr), .k_init_din(t_k_din),
    .v_init_en(t_v_en), .v_init_we_n(t_v_we_n), .v_init_addr(t_v_addr), .v_init_din(t_v_din),
    .attn_start(t_start), .attn_out_valid(t_out_valid), .attn_done(t_done),
    .busy(t_busy), .job_done(t_job_done), .job_ok(t_job_ok), .err_timeout(t_err_timeout),
    .err_count(t_err_count), .err_bad_sel(t_err_bad_sel), .out_cnt(t_out_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the main instance ----------------
  // Phase of the current job: 0 idle, 1 start, 2 run, 3 report.
  // Beats are counted raw (unbounded); saturation and the count error are
  // derived from the raw total when compared.
  int         m_ph = 0;
  int         m_run_cyc = 0;
  int         m_raw = 0;
  bit         m_tout = 0, m_cnterr = 0, m_ok = 0, m_bad = 0, m_wr_pend = 0;
  bit         m_go_acc;
  init_port_t m_wr = '0;
  logic [1:0] m_wr_sel = 2'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = 0; m_run_cyc = 0; m_raw = 0;
      m_tout = 0; m_cnterr = 0; m_ok = 0; m_bad = 0; m_wr_pend = 0;
      m_wr = '0;
    end else begin
      m_go_acc  = (m_ph == 0) && go_valid && !ld_valid && !m_wr_pend;
      m_wr_pend = (m_ph == 0) && ld_valid;
      m_wr.en   = 1'b0;
      if ((m_ph == 0) && ld_valid) begin
        if (ld_sel == 2'd3) m_bad = 1;
        else begin
          m_wr.en = 1'b1; m_wr_sel = ld_sel; m_wr.addr = ld_addr; m_wr.din = ld_data;
        end
      end
      case (m_ph)
        0: if (m_go_acc) begin
             m_ph = 1; m_raw = 0; m_tout = 0; m_cnterr = 0; m_ok = 0; m_bad = 0;
           end
        1: begin m_ph = 2; m_run_cyc = 0; end
        2: begin
             if (attn_out_valid) m_raw++;
             if (attn_done || m_run_cyc == TO_MAIN - 1) begin
               m_ph = 3;
               m_tout = !attn_done;
               m_cnterr = (m_raw != EXP);
               m_ok = attn_done && (m_raw == EXP);
             end else m_run_cyc++;
           end
        default: m_ph = 0;
      endcase
    end
  end

  int q_writes = 0, k_writes = 0, v_writes = 0, starts = 0, dones = 0;

  task automatic chk_port(input string nm, input int p, input logic en, input logic we_n,
                          input logic [6:0] a, input logic [127:0] d);
    bit e;
    e = m_wr.en && (m_wr_sel == 2'(p));
    check({nm, "_en"}, en, e);
    check({nm, "_we_n"}, we_n, !e);
    if (e) begin
      check({nm, "_addr"}, a, m_wr.addr);
      check({nm, "_din"}, d, m_wr.din);
    end
  endtask

  always @(negedge clk) begin
    check("ld_ready", ld_ready, m_ph == 0);
    check("go_ready", go_ready, (m_ph == 0) && !ld_valid && !m_wr_pend);
    check("busy", busy, m_ph != 0);
    check("attn_start", attn_start, m_ph == 1);
    check("job_done", job_done, m_ph == 3);
    check("out_cnt", out_cnt, (m_raw > EXP) ? EXP : m_raw);
    check("job_ok", job_ok, m_ok);
    check("err_timeout", err_timeout, m_tout);
    check("err_count", err_count, m_cnterr);
    check("err_bad_sel", err_bad_sel, m_bad);
    chk_port("q", 0, q_en, q_we_n, q_addr, q_din);
    chk_port("k", 1, k_en, k_we_n, k_addr, k_din);
    chk_port("v", 2, v_en, v_we_n, v_addr, v_din);
    if (q_en) q_writes++;
    if (k_en) k_writes++;
    if (v_en) v_writes++;
    if (attn_start) starts++;
    if (job_done) dones++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // returns at #1 after the accepting edge (inside the START cycle)
  task automatic go_accept(input string nm);
    bit ok;
    ok = 0;
    go_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (go_ready) begin
        tick();
        ok = 1;
      end
    end
    go_valid = 1'b0;
    check({nm, "_go_accepted"}, ok, 1'b1);
  endtask

  // attention-top stub: n beats, then done (or done with the last beat)
  task automatic stub(input int n, input bit with_last);
    tick();
    for (int i = 0; i < n; i++) begin
      attn_out_valid = 1'b1;
      attn_done = with_last && (i == n - 1);
      tick();
    end
    attn_out_valid = 1'b0;
    if (!with_last) begin
      attn_done = 1'b1;
      tick();
    end
    attn_done = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (job_done) seen = 1;
    end
    check({nm, "_job_done_seen"}, seen, 1'b1);
  endtask

  task automatic t_go_accept(input string nm);
    bit ok;
    ok = 0;
    t_go_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (t_go_ready) begin
        tick();
        ok = 1;
      end
    end
    t_go_valid = 1'b0;
    check({nm, "_go_accepted"}, ok, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit seen;
    int dones_saved;

    rst = 1'b1;
    ld_valid = 0; ld_sel = 0; ld_addr = 0; ld_data = 0; go_valid = 0;
    attn_out_valid = 0; attn_done = 0;
    t_ld_valid = 0; t_ld_sel = 0; t_ld_addr = 0; t_ld_data = 0; t_go_valid = 0;
    t_out_valid = 0; t_done = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_q_we_n", q_we_n, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_out_cnt", out_cnt, 8'd0);
    tick();
    rst = 1'b0;
    tick();

    // 1: 128 Q, 128 K, 128 V beats back-to-back
    for (int s = 0; s < 3; s++) begin
      for (int a = 0; a < 128; a++) begin
        ld_valid = 1'b1;
        ld_sel   = 2'(s);
        ld_addr  = 7'(a);
        ld_data  = {32'(s), 32'(a), 32'hC0DE0000 | 32'(a), 32'(s * 256 + a)};
        tick();
      end
    end
    ld_valid = 1'b0;
    tick(); tick();
    check("t1_q_writes", q_writes, 128);
    check("t1_k_writes", k_writes, 128);
    check("t1_v_writes", v_writes, 128);

    // 2: full job, 128 beats then done
    go_accept("t2");
    stub(128, 1'b0);
    wait_done("t2");
    check("t2_job_ok", job_ok, 1'b1);
    check("t2_out_cnt", out_cnt, 8'd128);
    check("t2_err_count", err_count, 1'b0);
    tick();
    check("t2_starts", starts, 1);

    // 3: short job then overflowing job
    go_accept("t3a");
    stub(127, 1'b0);
    wait_done("t3a");
    check("t3a_out_cnt", out_cnt, 8'd127);
    check("t3a_err_count", err_count, 1'b1);
    check("t3a_job_ok", job_ok, 1'b0);
    tick();
    go_accept("t3b");
    stub(130, 1'b0);
    wait_done("t3b");
    check("t3b_out_cnt", out_cnt, 8'd128);
    check("t3b_err_count", err_count, 1'b1);
    check("t3b_job_ok", job_ok, 1'b0);
    check("t3b_err_timeout", err_timeout, 1'b0);
    tick();

    // 4: watchdog with TIMEOUT=50, done never asserted
    t_go_accept("t4a");
    k = 0; seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (t_job_done) seen = 1;
    end
    check("t4a_done_seen", seen, 1'b1);
    check("t4a_latency", k, 51);
    check("t4a_err_timeout", t_err_timeout, 1'b1);
    check("t4a_job_ok", t_job_ok, 1'b0);
    check("t4a_err_count", t_err_count, 1'b1);
    tick();
    // second go accepted; done lands exactly on the timeout cycle and wins
    t_go_accept("t4b");
    repeat (50) tick();
    t_done = 1'b1;
    tick();
    t_done = 1'b0;
    @(negedge clk);
    check("t4b_job_done", t_job_done, 1'b1);
    check("t4b_err_timeout", t_err_timeout, 1'b0);
    tick();

    // 5: load and go together, an illegal-select beat
    ld_valid = 1'b1; ld_sel = 2'd3; ld_addr = 7'd9; ld_data = 128'hBAD;
    go_valid = 1'b1;
    tick();
    ld_sel = 2'd1; ld_addr = 7'd5; ld_data = 128'h1234_5678;
    tick();
    ld_valid = 1'b0;
    @(negedge clk);
    check("t5_go_ready_pend", go_ready, 1'b0);
    check("t5_bad_sel_set", err_bad_sel, 1'b1);
    tick();
    @(negedge clk);
    check("t5_go_ready_free", go_ready, 1'b1);
    tick();
    go_valid = 1'b0;
    @(negedge clk);
    check("t5_bad_sel_clr", err_bad_sel, 1'b0);
    check("t5_start", attn_start, 1'b1);
    stub(128, 1'b1);
    wait_done("t5");
    check("t5_job_ok", job_ok, 1'b1);
    check("t5_out_cnt", out_cnt, 8'd128);
    tick();
    check("t5_q_writes", q_writes, 128);
    check("t5_k_writes", k_writes, 129);
    check("t5_v_writes", v_writes, 128);

    // 6: reset in RUN at beat 60
    go_accept("t6a");
    tick();
    for (int i = 0; i < 60; i++) begin
      attn_out_valid = 1'b1;
      tick();
    end
    attn_out_valid = 1'b0;
    dones_saved = dones;
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_job_done", job_done, 1'b0);
    check("t6_rst_out_cnt", out_cnt, 8'd0);
    check("t6_rst_start", attn_start, 1'b0);
    check("t6_rst_k_we_n", k_we_n, 1'b1);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("t6_no_job_done", dones, dones_saved);
    go_accept("t6b");
    stub(128, 1'b0);
    wait_done("t6b");
    check("t6b_job_ok", job_ok, 1'b1);
    tick();
    check("total_starts", starts, 6);
    check("total_dones", dones, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
